systolic_array_stream: RTL
==========================

SYSTOLIC_ARRAY_STREAM -- requirements
Module: systolic_array_stream

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 16: signed operand width.
REQ-002 The block SHALL provide parameter ROWS, default 4: array rows, and the number of A operands per beat.
REQ-003 The block SHALL provide parameter COLS, default 4: array columns, and the number of B operands per beat.
REQ-004 The block SHALL provide parameter KMAX, default 64: maximum inner dimension.
REQ-005 The block SHALL derive localparam ACC_W = 2*WIDTH + $clog2(KMAX) for the signed accumulator width.
REQ-006 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1: begin a job; ignored while busy=1.
REQ-009 The block SHALL have port k_len, input, $clog2(KMAX+1): inner dimension, 0..KMAX; sampled when start is accepted.
REQ-010 The block SHALL have port acc_mode, input, 1, sampled when start is accepted: 0 = clear accumulators, 1 = add onto previous results.
REQ-011 The block SHALL have port a_valid / a_ready, input / output, 1 each: handshake for the A column stream.
REQ-012 The block SHALL have port a_data, input, ROWS*WIDTH: A[i][k] for all rows i; slice i = row i.
REQ-013 The block SHALL have port b_valid / b_ready, input / output, 1 each: handshake for the B row stream.
REQ-014 The block SHALL have port b_data, input, COLS*WIDTH: B[k][j] for all columns j; slice j = column j.
REQ-015 The block SHALL have port r_valid / r_ready, output / input, 1 each: handshake for the result stream.
REQ-016 The block SHALL have port r_data, output, COLS*ACC_W: one result row C[r_row][*].
REQ-017 The block SHALL have ports r_row, output, $clog2(ROWS): current row index; and r_last, output, 1: high on the last row.
REQ-018 The block SHALL have port busy, output, 1: high from start acceptance until done.
REQ-019 The block SHALL have port done, output, 1: one-cycle pulse at job end.

Function
REQ-020 The block SHALL compute C = A x B (C is ROWS x COLS, inner dimension k_len) with an output-stationary array; PE(i,j) owns C[i][j].
REQ-021 The FSM SHALL have states IDLE, LOAD, FLUSH, DRAIN and DONE.
REQ-022 IDLE SHALL move to LOAD on start (or straight to DRAIN when k_len=0) and SHALL clear the accumulators at this edge when acc_mode=0.
REQ-023 In LOAD, a_ready and b_ready SHALL both equal (state==LOAD); a beat is consumed only on a cycle with a_valid & b_valid & ready.
REQ-024 A cycle with only one stream valid SHALL consume nothing and SHALL inject zero operands as a bubble.
REQ-025 Row i of the A operands SHALL be skewed by i cycles, and column j of the B operands by j cycles, using internal delay registers.
REQ-026 LOAD SHALL move to FLUSH on the edge that consumes beat k_len; FLUSH SHALL inject zeros for exactly ROWS+COLS-1 cycles and then move to DRAIN.
REQ-027 PE arithmetic SHALL be signed: acc += a*b, with the product sign-extended to ACC_W; overflow is impossible for k_len<=KMAX.
REQ-028 In DRAIN, r_valid=1 with rows presented in order 0..ROWS-1; r_data and r_row SHALL be held stable while r_ready=0; r_last=1 iff r_row==ROWS-1.
REQ-029 The r_last handshake SHALL move DRAIN to DONE; DONE SHALL assert done for one cycle, then return to IDLE; busy=0 in IDLE.
REQ-030 start asserted in DONE or any other busy state SHALL be ignored.
REQ-031 Accumulators SHALL retain their values in IDLE so that a later acc_mode=1 job accumulates across tiles.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, all accumulators and skew registers 0, busy=0, done=0, a_ready=b_ready=0, r_valid=0, r_data=0, r_row=0, r_last=0.
REQ-033 Reset asserted mid-job SHALL abort the job with no partial outputs; the first start after reset SHALL behave as a fresh acc_mode=0 job.

Structure
REQ-034 A package sa_pkg SHALL hold the state enum sa_state_t and the function computing ACC_W.
REQ-035 A sub-module sa_pe (one MAC, pass-through a and b registers, and the accumulator with clear) SHALL be instantiated ROWS x COLS times with a generate loop.

Verification (ROWS=COLS=4, WIDTH=16, KMAX=64)
REQ-036 Identity: A=I, B[k][j]=10k+j, k_len=4 -> the four drained rows SHALL equal the rows of B; done SHALL pulse once.
REQ-037 Sign mix: A[i][k]=+1 for k<2 and -1 for k>=2, B[k][j]=10k+10j, acc_mode=0 -> every C SHALL be -40; the same job repeated with acc_mode=1 -> every C SHALL be -80.
REQ-038 Backpressure: a_valid low on alternate cycles and r_ready low for 5 cycles on row 1 -> results as in REQ-037 (-40); r_data and r_row SHALL be stable during the stall.
REQ-039 Extremes: all operands -32768, k_len=64 -> every C SHALL be 2^36; k_len=0, acc_mode=0 -> four rows of 0, no A/B beats consumed.
REQ-040 Reset during LOAD after 2 beats -> outputs SHALL be at reset values at once; a new REQ-036 job SHALL then pass.

Source files
------------

// File: rtl/sa_pkg.sv
// sa_pkg: shared FSM state type and width helper for the systolic array.
package sa_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StFlush,
      StDrain,
      StDone
   } sa_state_t;

   // Full signed product width plus headroom for kmax accumulations.
   function automatic int unsigned acc_width(input int unsigned width, input int unsigned kmax);
      return 2 * width + $clog2(kmax);
   endfunction

endpackage

// File: rtl/sa_pe.sv
// sa_pe: one output-stationary processing element. Registers the incoming
// operands towards the right/lower neighbours and keeps a signed accumulator.
module sa_pe
   import sa_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ACC_W = 38
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic                    clr,
   input  logic signed [WIDTH-1:0] a_in,
   input  logic signed [WIDTH-1:0] b_in,
   output logic signed [WIDTH-1:0] a_out,
   output logic signed [WIDTH-1:0] b_out,
   output logic signed [ACC_W-1:0] acc
);

   localparam int unsigned PW = 2 * WIDTH;

   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext;

   assign prod     = PW'(a_in) * PW'(b_in);
   assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

   // Operand pass-through: a moves right, b moves down, one cycle per PE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_out <= '0;
         b_out <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
      end
   end

   // Accumulator: clear has priority; holds its value whenever en is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod_ext;
      end
   end

endmodule

// File: rtl/systolic_array_stream.sv
// systolic_array_stream: streams A columns and B rows into a ROWS x COLS
// output-stationary array, then drains C one row per handshake.
module systolic_array_stream
   import sa_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ROWS  = 4,
   parameter int unsigned COLS  = 4,
   parameter int unsigned KMAX  = 64,
   localparam int unsigned ACC_W = acc_width(WIDTH, KMAX),
   localparam int unsigned KW    = $clog2(KMAX + 1),
   localparam int unsigned RW    = $clog2(ROWS)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   input  logic                    acc_mode,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [ROWS*WIDTH-1:0]   a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [COLS*WIDTH-1:0]   b_data,
   output logic                    r_valid,
   input  logic                    r_ready,
   output logic [COLS*ACC_W-1:0]   r_data,
   output logic [RW-1:0]           r_row,
   output logic                    r_last,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned   FW         = $clog2(ROWS + COLS) + 1;
   // Flush lasts ROWS+COLS-1 cycles: counter runs 0..ROWS+COLS-2.
   localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
   localparam logic [FW-1:0] F_ONE      = FW'(1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
   localparam logic [RW-1:0] R_ONE      = RW'(1);
   localparam logic [KW-1:0] K_ONE      = KW'(1);

   sa_state_t     state_q;
   logic [KW-1:0] k_len_q;
   logic [KW-1:0] beat_q;
   logic [FW-1:0] flush_q;
   logic [RW-1:0] row_q;

   logic fire;
   logic mac_en;
   logic acc_clr;

   logic signed [WIDTH-1:0] a_h    [ROWS][COLS];
   logic signed [WIDTH-1:0] b_v    [ROWS][COLS];
   logic signed [ACC_W-1:0] pe_acc [ROWS][COLS];

   assign a_ready = (state_q == StLoad);
   assign b_ready = a_ready;
   assign fire    = a_ready & a_valid & b_valid;
   assign mac_en  = (state_q == StLoad) | (state_q == StFlush);
   assign acc_clr = (state_q == StIdle) & start & ~acc_mode;
   assign busy    = (state_q != StIdle);
   assign done    = (state_q == StDone);
   assign r_valid = (state_q == StDrain);
   assign r_row   = row_q;
   assign r_last  = r_valid & (row_q == ROW_LAST);

   // Job sequencing: accept start, count beats, time the flush, walk the drain rows.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         k_len_q <= '0;
         beat_q  <= '0;
         flush_q <= '0;
         row_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  k_len_q <= k_len;
                  beat_q  <= '0;
                  flush_q <= '0;
                  row_q   <= '0;
                  state_q <= (k_len == '0) ? StDrain : StLoad;
               end
            end
            StLoad: begin
               if (fire) begin
                  beat_q <= beat_q + K_ONE;
                  if (beat_q + K_ONE == k_len_q) begin
                     flush_q <= '0;
                     state_q <= StFlush;
                  end
               end
            end
            StFlush: begin
               if (flush_q == FLUSH_LAST) begin
                  state_q <= StDrain;
               end else begin
                  flush_q <= flush_q + F_ONE;
               end
            end
            StDrain: begin
               if (r_ready) begin
                  if (row_q == ROW_LAST) begin
                     row_q   <= '0;
                     state_q <= StDone;
                  end else begin
                     row_q <= row_q + R_ONE;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Row i of A enters i cycles late so it meets the matching B skew.
   for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
      logic signed [WIDTH-1:0] a_beat;
      assign a_beat = fire ? a_data[i*WIDTH +: WIDTH] : '0;
      if (i == 0) begin : g_direct
         assign a_h[0][0] = a_beat;
      end else begin : g_delay
         logic signed [WIDTH-1:0] dly_q [i];
         // i-stage delay line; idle cycles shift zeros through.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int d = 0; d < i; d++) dly_q[d] <= '0;
            end else begin
               dly_q[0] <= a_beat;
               for (int d = 1; d < i; d++) dly_q[d] <= dly_q[d-1];
            end
         end
         assign a_h[i][0] = dly_q[i-1];
      end
   end

   // Column j of B enters j cycles late.
   for (genvar j = 0; j < COLS; j++) begin : g_b_skew
      logic signed [WIDTH-1:0] b_beat;
      assign b_beat = fire ? b_data[j*WIDTH +: WIDTH] : '0;
      if (j == 0) begin : g_direct
         assign b_v[0][0] = b_beat;
      end else begin : g_delay
         logic signed [WIDTH-1:0] dly_q [j];
         // j-stage delay line; idle cycles shift zeros through.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               for (int d = 0; d < j; d++) dly_q[d] <= '0;
            end else begin
               dly_q[0] <= b_beat;
               for (int d = 1; d < j; d++) dly_q[d] <= dly_q[d-1];
            end
         end
         assign b_v[0][j] = dly_q[j-1];
      end
   end

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      for (genvar j = 0; j < COLS; j++) begin : g_col
         logic signed [WIDTH-1:0] a_nxt;
         logic signed [WIDTH-1:0] b_nxt;

         sa_pe #(
            .WIDTH (WIDTH),
            .ACC_W (ACC_W)
         ) u_pe (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (mac_en),
            .clr     (acc_clr),
            .a_in    (a_h[i][j]),
            .b_in    (b_v[i][j]),
            .a_out   (a_nxt),
            .b_out   (b_nxt),
            .acc     (pe_acc[i][j])
         );

         if (j < COLS - 1) begin : g_a_fwd
            assign a_h[i][j+1] = a_nxt;
         end else begin : g_a_end
            logic signed [WIDTH-1:0] a_unused;
            assign a_unused = a_nxt;
         end

         if (i < ROWS - 1) begin : g_b_fwd
            assign b_v[i+1][j] = b_nxt;
         end else begin : g_b_end
            logic signed [WIDTH-1:0] b_unused;
            assign b_unused = b_nxt;
         end
      end
   end

   // Present the accumulator row selected by row_q; zero outside the drain.
   always_comb begin
      r_data = '0;
      for (int j = 0; j < COLS; j++) begin
         if (r_valid) r_data[j*ACC_W +: ACC_W] = pe_acc[row_q][j];
      end
   end

endmodule
